// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetcher: bus widths, fetch FSM
// encodings, the FIFO entry layout and the word-alignment helper.
package inst_prefetch_pkg;

  localparam int XLEN              = 32;
  localparam int INST_STEP_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] data;
  } fifo_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch buffer: DEPTH entries of {tag, data} with extra-MSB pointers so
// full and empty are distinguishable without a separate counter.
module prefetch_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fifo_entry_t              i_wdata,
  output fifo_entry_t              o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t      r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // NOTE: storage is deliberately left out of reset; the pointers alone decide
  // which entries are live, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher between a core fetch port and a
// single-outstanding req/gnt/rvalid memory; serves hits with zero latency.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int INST_STEP = INST_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] inst_o,
  output logic            inst_valid_o,
  output logic            stall_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_next_addr;
  logic [XLEN-1:0] r_mem_addr;
  logic            r_discard;

  logic [XLEN-1:0] w_pc_tag;
  logic [XLEN-1:0] w_issue_addr;
  fifo_entry_t     w_head;
  fifo_entry_t     w_wentry;
  logic            w_empty;
  logic            w_full;
  logic [AW:0]     w_count;
  logic [AW:0]     w_occ_next;
  logic            w_hit;
  logic            w_inflight_match;
  logic            w_redirect;
  logic            w_push;
  logic            w_space;

  assign w_pc_tag = word_align(pc_i);
  assign w_hit    = ce_i && !w_empty && (w_head.tag == w_pc_tag);

  // A request already heading for pc_i (and not doomed) makes a miss a plain wait.
  assign w_inflight_match = (r_state != ST_IDLE) && !r_discard && (r_mem_addr == w_pc_tag);
  assign w_redirect       = ce_i && !w_hit && !w_inflight_match;

  assign w_push   = (r_state == ST_WAIT) && mem_rvalid_i && !r_discard && !w_redirect && !w_full;
  assign w_wentry = '{tag: r_mem_addr, data: mem_rdata_i};

  // Occupancy after this edge; the request slot is free whenever we may issue.
  assign w_occ_next   = w_redirect ? '0
                      : w_count + (AW+1)'(w_push) - (AW+1)'(w_hit);
  assign w_space      = w_occ_next < (AW+1)'(DEPTH);
  assign w_issue_addr = w_redirect ? w_pc_tag : word_align(r_next_addr);

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_hit),
    .i_flush (w_redirect),
    .i_wdata (w_wentry),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // NOTE: every register here uses <= so all state moves together at the edge;
  // the later redirect assignments intentionally override the FSM's defaults.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_next_addr <= '0;
      r_mem_addr  <= '0;
      r_discard   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_space) begin
            r_state    <= ST_REQ;
            r_mem_addr <= w_issue_addr;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            r_state <= ST_WAIT;
            if (!r_discard && !w_redirect) r_next_addr <= r_mem_addr + XLEN'(INST_STEP);
          end
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            r_discard <= 1'b0;
            if (w_space) begin
              r_state    <= ST_REQ;
              r_mem_addr <= w_issue_addr;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Address held on the bus stays put; only its eventual data is dropped.
      if (w_redirect) begin
        r_next_addr <= w_pc_tag;
        if (r_state == ST_REQ || (r_state == ST_WAIT && !mem_rvalid_i)) r_discard <= 1'b1;
      end
    end
  end

  assign mem_req_o    = (r_state == ST_REQ);
  assign mem_addr_o   = r_mem_addr;
  assign inst_valid_o = w_hit;
  assign inst_o       = w_hit ? w_head.data : '0;
  assign stall_o      = ce_i && !w_hit;

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: a behavioural memory with programmable
// grant enable and read latency, and scenario tasks with hand-derived expectations.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state
  logic        gnt_en = 1'b1;
  int          rvalid_lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic [31:0] gnt_addr = '0;
  logic [31:0] gnt_log[$];

  inst_prefetch #(.DEPTH(4), .INST_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // Memory: a grant offered at one negedge is taken at the following posedge;
  // its data appears rvalid_lat cycles later.
  always @(negedge clk) begin
    if (mem_gnt_i === 1'b1) begin
      pend      = 1'b1;
      pend_addr = gnt_addr;
      pend_cnt  = rvalid_lat;
      gnt_log.push_back(gnt_addr);
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(pend_addr);
        pend         = 1'b0;
      end
    end
    mem_gnt_i = gnt_en && (mem_req_o === 1'b1) && !pend;
    gnt_addr  = mem_addr_o;
  end

  task automatic cyc(input logic ce, input logic [31:0] pc);
    @(negedge clk);
    ce_i = ce;
    pc_i = pc;
    #1;
  endtask

  task automatic run_until_valid(input logic [31:0] pc, input int budget,
                                 output logic got, output int bad_stall);
    got = 1'b0;
    bad_stall = 0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc(1'b1, pc);
      if (inst_valid_o === 1'b1) got = 1'b1;
      else if (stall_o !== 1'b1) bad_stall++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 32'h0);
    n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    n_checks++; if (inst_o !== 32'h0) begin n_errors++; $display("FAIL reset_inst: got %h want 0", inst_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    cyc(1'b0, 32'h0);
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      n_errors++; $display("FAIL first_req: req %b addr %h want 1 00000000", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_fill_hits;
    logic [31:0] pc;
    repeat (9) cyc(1'b0, 32'h0);
    n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL fill_req_drop: got %b want 0", mem_req_o); end
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k * 4);
      cyc(1'b1, pc);
      n_checks++; if (inst_valid_o !== 1'b1 || stall_o !== 1'b0) begin
        n_errors++; $display("FAIL fill_hit%0d: valid %b stall %b want 1 0", k, inst_valid_o, stall_o);
      end
      n_checks++; if (inst_o !== mem_word(pc)) begin
        n_errors++; $display("FAIL fill_data%0d: got %h want %h", k, inst_o, mem_word(pc));
      end
    end
  endtask

  task automatic test_redirect_flush;
    logic got;
    int   bad;
    run_until_valid(32'h10, 10, got, bad);
    n_checks++; if (got !== 1'b1 || inst_o !== mem_word(32'h10)) begin
      n_errors++; $display("FAIL seq_0x10: got %h want %h (valid seen %b)", inst_o, mem_word(32'h10), got);
    end
    repeat (10) cyc(1'b0, 32'h0);
    n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL refill_idle: req %b want 0", mem_req_o); end
    cyc(1'b1, 32'h200);
    n_checks++; if (stall_o !== 1'b1 || inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin
      n_errors++; $display("FAIL jump_miss: stall %b valid %b inst %h want 1 0 0", stall_o, inst_valid_o, inst_o);
    end
    cyc(1'b1, 32'h200);
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      n_errors++; $display("FAIL jump_req: req %b addr %h want 1 00000200", mem_req_o, mem_addr_o);
    end
    run_until_valid(32'h200, 10, got, bad);
    n_checks++; if (got !== 1'b1 || bad != 0) begin
      n_errors++; $display("FAIL jump_wait: valid seen %b, unstalled misses %0d want 1 0", got, bad);
    end
    n_checks++; if (inst_o !== mem_word(32'h200)) begin
      n_errors++; $display("FAIL jump_data: got %h want %h", inst_o, mem_word(32'h200));
    end
    cyc(1'b1, 32'h14);
    n_checks++; if (inst_valid_o !== 1'b0 || stall_o !== 1'b1) begin
      n_errors++; $display("FAIL flushed_0x14: valid %b stall %b want 0 1", inst_valid_o, stall_o);
    end
  endtask

  task automatic test_redirect_wait;
    logic got;
    int   bad;
    logic found;
    rvalid_lat = 4;
    run_until_valid(32'h10, 20, got, bad);
    n_checks++; if (got !== 1'b1 || inst_o !== mem_word(32'h10)) begin
      n_errors++; $display("FAIL rw_0x10: got %h want %h (valid seen %b)", inst_o, mem_word(32'h10), got);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc(1'b0, 32'h0);
      if (pend && pend_addr == 32'h18) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rw_wait18: grant for 00000018 seen %b want 1", found); end
    gnt_log.delete();
    run_until_valid(32'h200, 40, got, bad);
    n_checks++; if (got !== 1'b1 || inst_o !== mem_word(32'h200)) begin
      n_errors++; $display("FAIL rw_stale: got %h want %h (valid seen %b)", inst_o, mem_word(32'h200), got);
    end
    n_checks++; if (gnt_log.size() == 0 || gnt_log[0] !== 32'h200) begin
      n_errors++; $display("FAIL rw_next_req: first grant %h want 00000200 (count %0d)",
                           (gnt_log.size() == 0) ? 32'hx : gnt_log[0], gnt_log.size());
    end
  endtask

  task automatic test_gnt_hold;
    logic got;
    int   bad;
    rvalid_lat = 1;
    repeat (16) cyc(1'b0, 32'h0);
    n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL hold_pre_idle: req %b want 0", mem_req_o); end
    gnt_en = 1'b0;
    cyc(1'b1, 32'h300);
    cyc(1'b1, 32'h300);
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin
      n_errors++; $display("FAIL hold_req: req %b addr %h want 1 00000300", mem_req_o, mem_addr_o);
    end
    bad = 0;
    repeat (5) begin
      cyc(1'b1, 32'h300);
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300 || stall_o !== 1'b1 || inst_valid_o !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad); end
    cyc(1'b1, 32'h400);
    cyc(1'b1, 32'h400);
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin
      n_errors++; $display("FAIL hold_redirect_addr: req %b addr %h want 1 00000300", mem_req_o, mem_addr_o);
    end
    gnt_log.delete();
    gnt_en = 1'b1;
    run_until_valid(32'h400, 30, got, bad);
    n_checks++; if (got !== 1'b1 || inst_o !== mem_word(32'h400)) begin
      n_errors++; $display("FAIL hold_data: got %h want %h (valid seen %b)", inst_o, mem_word(32'h400), got);
    end
    n_checks++; if (gnt_log.size() < 2 || gnt_log[0] !== 32'h300 || gnt_log[1] !== 32'h400) begin
      n_errors++; $display("FAIL hold_grant_order: grants %0d, want 00000300 then 00000400", gnt_log.size());
    end
  endtask

  task automatic test_reset_mid;
    logic got;
    int   bad;
    logic found;
    rvalid_lat = 6;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1'b1, 32'h500);
      if (pend && pend_addr == 32'h500) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rm_wait500: grant seen %b want 1", found); end
    gnt_en = 1'b0;
    @(negedge clk); rst = 1'b0; ce_i = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; ce_i = 1'b1; pc_i = 32'h0;
    #1;
    cyc(1'b1, 32'h0);
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      n_errors++; $display("FAIL rm_first_req: req %b addr %h want 1 00000000", mem_req_o, mem_addr_o);
    end
    n_checks++; if (inst_valid_o !== 1'b0 || stall_o !== 1'b1) begin
      n_errors++; $display("FAIL rm_empty: valid %b stall %b want 0 1", inst_valid_o, stall_o);
    end
    bad = 0;
    for (int i = 0; i < 10 && pend; i++) begin
      cyc(1'b1, 32'h0);
      if (inst_valid_o !== 1'b0) bad++;
    end
    cyc(1'b1, 32'h0);
    n_checks++; if (pend !== 1'b0 || bad != 0 || inst_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL rm_late_rvalid: still pending %b, valid cycles %0d want 0 0", pend, bad);
    end
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      n_errors++; $display("FAIL rm_req_held: req %b addr %h want 1 00000000", mem_req_o, mem_addr_o);
    end
    gnt_en = 1'b1;
    run_until_valid(32'h0, 10, got, bad);
    n_checks++; if (got !== 1'b1 || inst_o !== mem_word(32'h0)) begin
      n_errors++; $display("FAIL rm_data: got %h want %h (valid seen %b)", inst_o, mem_word(32'h0), got);
    end
  endtask

  task automatic test_sequential;
    logic        got;
    int          bad;
    logic [31:0] pc;
    rvalid_lat = 1;
    for (int k = 1; k < 16; k++) begin
      pc = 32'(k * 4);
      run_until_valid(pc, 8, got, bad);
      n_checks++; if (got !== 1'b1 || inst_o !== mem_word(pc)) begin
        n_errors++; $display("FAIL seq_word_%h: got %h want %h (valid seen %b)", pc, inst_o, mem_word(pc), got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_hits();
    test_redirect_flush();
    test_redirect_wait();
    test_gnt_hold();
    test_reset_mid();
    test_sequential();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
